// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// - RV64I load/store funct3 encodings.
// - LSU state type.
// - Byte-strobe constants for each access size.
// - Helpers that map funct3 to a base strobe and detect misaligned addresses.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // funct3[1:0] carries the access size for both the signed and unsigned forms.
  function automatic logic [7:0] size_strb(input logic [2:0] f3);
    logic [7:0] s;
    case (f3[1:0])
      2'b00:   s = STRB_B;
      2'b01:   s = STRB_H;
      2'b10:   s = STRB_W;
      default: s = STRB_D;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    logic m;
    case (f3[1:0])
      2'b01:   m = a[0];
      2'b10:   m = |a[1:0];
      2'b11:   m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port bundle between the LSU and the data memory.
//   master (LSU): drives dmem_req/we/addr/wdata/wstrb and samples dmem_ready/rdata.
//   slave (memory): the mirror image.
// dmem_addr is doubleword aligned. dmem_wstrb is zero for reads.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_extract.sv
// Combinational load-data extraction.
// Ports:
//   rdata   in  64  aligned doubleword returned by memory
//   addr_lo in  3   byte offset of the access within the doubleword
//   funct3  in  3   load size/sign encoding
//   result  out 64  selected bytes, sign- or zero-extended to 64 bits
module load_extract
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   result = {56'd0, shifted[7:0]};
      F3_HU:   result = {48'd0, shifted[15:0]};
      F3_WU:   result = {32'd0, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit between the EX/MEM and MEM/WB registers.
// Issues one request/ready access per memory op, aligns stores into byte
// lanes, extends loads, and stalls the upstream pipeline while busy.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   MEM_MemRead     load in MEM stage
//   MEM_MemWrite    store in MEM stage (both set is illegal)
//   MEM_funct3      access size/sign
//   MEM_ALUresult   effective byte address
//   MEM_WriteData   LSB-justified store data
//   MEM_RegWrite    writeback enable from EX/MEM
//   MEM_MemData     extended load result (0 unless a load completes)
//   MEM_RegWriteQ   writeback enable to MEM/WB (0 while stalled or faulting)
//   stall           freeze the upstream pipeline registers
//   fault           one-cycle pulse: misaligned, illegal, or bus timeout
//   dmem            data-memory port (master side)
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_MemRead,
  input  logic                   MEM_MemWrite,
  input  logic [2:0]             MEM_funct3,
  input  logic [63:0]            MEM_ALUresult,
  input  logic [63:0]            MEM_WriteData,
  input  logic                   MEM_RegWrite,
  output logic [63:0]            MEM_MemData,
  output logic                   MEM_RegWriteQ,
  output logic                   stall,
  output logic                   fault,
  mem_stage_lsu_if.master        dmem
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  lane_q, lane_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  strb_q, strb_d;
  logic [2:0]  f3_q, f3_d;
  logic        is_load_q, is_load_d;
  logic [63:0] rdata_q, rdata_d;
  logic [15:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;

  logic        mem_op, illegal, op_bad, op_ok;
  logic [7:0]  st_strb;
  logic [63:0] st_wdata;
  logic [15:0] timer_inc;
  logic [63:0] ext_result;

  load_extract u_extract (
    .rdata   (rdata_q),
    .addr_lo (lane_q),
    .funct3  (f3_q),
    .result  (ext_result)
  );

  always_comb begin
    mem_op  = MEM_MemRead | MEM_MemWrite;
    illegal = (MEM_MemRead & MEM_MemWrite)
            | (MEM_MemRead & (MEM_funct3 == 3'b111))
            | (MEM_MemWrite & MEM_funct3[2]);
    op_bad  = mem_op & (illegal | misaligned(MEM_funct3, MEM_ALUresult[2:0]));
    op_ok   = mem_op & ~op_bad;

    st_strb  = size_strb(MEM_funct3) << MEM_ALUresult[2:0];
    st_wdata = MEM_WriteData << {MEM_ALUresult[2:0], 3'b000};

    timer_inc = (timer_q == '1) ? timer_q : timer_q + 16'd1;
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    f3_d          = f3_q;
    is_load_d     = is_load_q;
    rdata_d       = rdata_q;
    timer_d       = timer_q;
    timeout_d     = timeout_q;
    stall         = 1'b0;
    fault         = 1'b0;
    MEM_RegWriteQ = 1'b0;
    MEM_MemData   = '0;

    case (state_q)
      IDLE: begin
        if (op_ok) begin
          stall     = 1'b1;
          req_d     = 1'b1;
          we_d      = MEM_MemWrite;
          addr_d    = {MEM_ALUresult[63:3], 3'b000};
          lane_d    = MEM_ALUresult[2:0];
          wdata_d   = MEM_MemWrite ? st_wdata : '0;
          strb_d    = MEM_MemWrite ? st_strb  : '0;
          f3_d      = MEM_funct3;
          is_load_d = MEM_MemRead;
          timer_d   = '0;
          timeout_d = 1'b0;
          state_d   = BUSY;
        end else if (op_bad) begin
          fault = 1'b1;
        end else begin
          MEM_RegWriteQ = MEM_RegWrite;
        end
      end

      BUSY: begin
        stall = 1'b1;
        // A ready arriving on the same cycle the timer would expire still completes.
        if (dmem.dmem_ready) begin
          rdata_d = dmem.dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT_W) begin
            req_d     = 1'b0;
            timeout_d = 1'b1;
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        if (timeout_q) begin
          fault = 1'b1;
        end else begin
          MEM_RegWriteQ = MEM_RegWrite;
          if (is_load_q) MEM_MemData = ext_result;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      f3_q      <= '0;
      is_load_q <= 1'b0;
      rdata_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      f3_q      <= f3_d;
      is_load_q <= is_load_d;
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = req_q & we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = strb_q;

endmodule
